imem_boot_arbiter: RTL and testbench
====================================

// Module: imem_boot_arbiter
// PURPOSE
//  Sequences the instruction memory between two users: the core fetch port and a byte-stream boot loader.
//  On a boot request the block holds the core in reset and accepts a length header plus instruction bytes.
//  It packs the bytes into little-endian words and writes them to instruction memory from word 0 upward.
//  It then releases the core.
//  Sits between the core's PC/instruction path and the 1024x32 instruction memory array.
// PARAMETERS
//  ADDR_W        10   word-address width; memory holds DEPTH words
//  DEPTH         1024 max words loadable; header N > DEPTH is an error
//  BOOT_ON_RESET 0    1: leave reset directly into HDR (core held until load completes); 0: leave reset into IDLE
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       async reset, active-low (0 = reset)
//  boot_req   in   1       level, sampled only in IDLE; 1 starts a load
//  rx_data    in   8       loader byte
//  rx_valid   in   1       rx_data valid
//  rx_ready   out  1       byte accepted when rx_valid & rx_ready
//  core_pc    in   32      core fetch byte address
//  core_instr out  32      instruction to core
//  core_rst   out  1       active-low reset to core; 0 while loading
//  mem_we     out  1       memory write enable (synchronous write)
//  mem_addr   out  ADDR_W  memory word address
//  mem_wdata  out  32      memory write data
//  mem_rdata  in   32      memory read data (combinational read of mem[mem_addr])
//  boot_busy  out  1       1 in HDR/DATA/WRITE/RELEASE
//  boot_done  out  1       sticky; set on successful load, cleared on next load start
//  boot_err   out  1       sticky; set on bad header, cleared on next load start
// BEHAVIOUR
//  Reset (rst=0): state = IDLE (HDR if BOOT_ON_RESET); core_rst=0, rx_ready=0, mem_we=0, boot_done=0, boot_err=0.
//  Reset: byte/word counters and the partial word are cleared.
//  Reset mid-load: abort; partial word discarded; words already written stay in memory.
//  States and transitions:
//   IDLE    -> HDR when boot_req=1.
//   HDR     -> collects 4 bytes as header N (LE). After the 4th byte:
//              N==0 or N>DEPTH -> ERR; otherwise -> DATA.
//   DATA    -> collects 4 bytes (LE: first byte = bits[7:0]), then -> WRITE.
//   WRITE   -> one cycle, mem_we=1, mem_addr=word_idx, word_idx++.
//              Then -> RELEASE if word_idx+1==N, else -> DATA.
//   RELEASE -> one cycle, sets boot_done, then -> IDLE.
//   ERR     -> one cycle, sets boot_err, then -> IDLE; no memory writes.
//  rx_ready: 1 only in HDR and DATA (registered from next state). Consumes at most 1 byte per clock; bubbles on rx_valid are allowed.
//  core_rst: registered, <= (next_state==IDLE). Rises one clk after the last WRITE->RELEASE path returns to IDLE.
//  core_rst: after reset into IDLE, it is 1 from the first clock edge.
//  Arbitration: in IDLE, mem_addr=core_pc[ADDR_W+1:2], mem_we=0, core_instr=mem_rdata.
//  Arbitration: outside IDLE, mem_addr=word_idx and core_instr=32'h0. Core fetches are never serviced during a load.
//  boot_req in any state other than IDLE is ignored. boot_done and boot_err clear on IDLE->HDR.
//  Counters: byte_cnt 2 bits wraps 3->0; word_idx ADDR_W+1 bits; header compared as full 32 bits; N==DEPTH is legal.
//  core_pc bits [1:0] and bits above ADDR_W+1 are ignored (address wraps modulo DEPTH).
// STRUCTURE
//  imem_boot_pkg: state enum (IDLE,HDR,DATA,WRITE,RELEASE,ERR), HDR_BYTES=4, NOP/zero instr constant.
//  Sub-module imem_word_assembler: 4-byte LE shift register plus 2-bit count; outputs word and word_full pulse.
//  Sub-module imem_word_assembler is shared by HDR and DATA.
// TESTING
//  1 BOOT_ON_RESET=0, mem preloaded, release rst, core_pc=4 -> core_rst=1 after 1st edge, core_instr=mem[1].
//  2 boot_req, bytes 02 00 00 00 13 05 10 00 93 05 20 00 -> mem[0]=00100513, mem[1]=00200593.
//    Expected for 2: boot_done=1, core_rst low throughout, high 1 clk after RELEASE.
//  3 header 00 00 00 00, and separately 01 04 00 00 (N=1025) -> boot_err=1, no mem_we pulse, core_rst back to 1.
//  4 repeat 2 with rx_valid toggling every other cycle -> identical memory contents; no byte lost or duplicated.
//  5 rst=0 after header N=2 plus 6 data bytes -> mem[0] written, mem[1] unchanged.
//    Expected for 5: rx_ready=0, core_rst=0 during reset, then IDLE.
//  6 boot_req pulsed during DATA, core_pc swept during load -> no restart, no extra writes, core_instr=0 until release.

Source files
------------

// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot sequencer.
package imem_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WRITE,
        ST_RELEASE,
        ST_ERR
    } state_t;

    localparam int unsigned HDR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs a byte stream into little-endian 32-bit words; shared by header and data phases.
module imem_word_assembler
    import imem_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_push,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic [31:0] o_word_next,
    output logic        o_word_full
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;

    // New bytes enter at the top so the first byte ends up in bits [7:0].
    assign o_word_next = {i_byte, r_word[31:8]};
    assign o_word      = r_word;
    assign o_word_full = i_push && (r_cnt == 2'(HDR_BYTES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_push) begin
            r_cnt  <= r_cnt + 2'd1;
            r_word <= o_word_next;
        end
    end

endmodule

// File: rtl/imem_boot_arbiter.sv
// Arbitrates instruction memory between core fetch and a byte-stream boot loader.
module imem_boot_arbiter
    import imem_boot_pkg::*;
#(
    parameter int ADDR_W        = 10,
    parameter int DEPTH         = 1024,
    parameter bit BOOT_ON_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [31:0]       core_pc,
    output logic [31:0]       core_instr,
    output logic              core_rst,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              boot_busy,
    output logic              boot_done,
    output logic              boot_err
);

    localparam state_t RST_STATE = BOOT_ON_RESET ? ST_HDR : ST_IDLE;

    state_t          r_state, w_next;
    logic [ADDR_W:0] r_word_idx;
    logic [31:0]     r_hdr_n;
    logic            r_rx_ready, r_core_rst, r_done, r_err;
    logic            w_push, w_start, w_full, w_last;
    logic [31:0]     w_word, w_word_next;
    logic            w_unused_pc;

    assign w_unused_pc = ^{core_pc[31:ADDR_W+2], core_pc[1:0]};
    assign w_push      = rx_valid & r_rx_ready;
    assign w_start     = (r_state == ST_IDLE) & boot_req;
    assign w_last      = (32'(r_word_idx) + 32'd1) == r_hdr_n;

    imem_word_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_start),
        .i_push      (w_push),
        .i_byte      (rx_data),
        .o_word      (w_word),
        .o_word_next (w_word_next),
        .o_word_full (w_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= RST_STATE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        mem_we     = 1'b0;
        mem_addr   = r_word_idx[ADDR_W-1:0];
        core_instr = NOP_INSTR;
        boot_busy  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                mem_addr   = core_pc[ADDR_W+1:2];
                core_instr = mem_rdata;
                if (boot_req) w_next = ST_HDR;
            end
            ST_HDR: begin
                boot_busy = 1'b1;
                if (w_full) begin
                    if (w_word_next == 32'd0 || w_word_next > 32'(DEPTH)) w_next = ST_ERR;
                    else                                                  w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                boot_busy = 1'b1;
                if (w_full) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                boot_busy = 1'b1;
                mem_we    = 1'b1;
                w_next    = w_last ? ST_RELEASE : ST_DATA;
            end
            ST_RELEASE: begin
                boot_busy = 1'b1;
                w_next    = ST_IDLE;
            end
            ST_ERR:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_idx <= '0;
            r_hdr_n    <= '0;
            r_rx_ready <= 1'b0;
            r_core_rst <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rx_ready <= (w_next == ST_HDR) || (w_next == ST_DATA);
            r_core_rst <= (w_next == ST_IDLE);
            if (w_start) begin
                r_word_idx <= '0;
                r_done     <= 1'b0;
                r_err      <= 1'b0;
            end
            if (r_state == ST_HDR && w_full) r_hdr_n <= w_word_next;
            if (r_state == ST_WRITE)         r_word_idx <= r_word_idx + 1'b1;
            if (r_state == ST_RELEASE)       r_done <= 1'b1;
            if (r_state == ST_ERR)           r_err <= 1'b1;
        end
    end

    assign rx_ready  = r_rx_ready;
    assign core_rst  = r_core_rst;
    assign mem_wdata = w_word;
    assign boot_done = r_done;
    assign boot_err  = r_err;

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Directed bench for imem_boot_arbiter with a behavioural 1024x32 instruction memory.
module tb_imem_boot_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        boot_req = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] core_pc = '0;
    logic [31:0] core_instr;
    logic        core_rst;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        boot_busy, boot_done, boot_err;

    logic [31:0] mem [0:1023];
    logic        tb_we = 1'b0;
    logic [9:0]  tb_addr = '0;
    logic [31:0] tb_wdata = '0;
    logic [7:0]  bq [0:11];

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int rst_bad = 0;
    int we0, bad0;
    logic mon_rst = 1'b0;

    always #5 clk = ~clk;

    imem_boot_arbiter #(.ADDR_W(10), .DEPTH(1024), .BOOT_ON_RESET(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .boot_req   (boot_req),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .core_pc    (core_pc),
        .core_instr (core_instr),
        .core_rst   (core_rst),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .boot_busy  (boot_busy),
        .boot_done  (boot_done),
        .boot_err   (boot_err)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_wdata;
        end
    end

    always @(negedge clk) if (mon_rst && core_rst !== 1'b0) rst_bad <= rst_bad + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic stream(input int first, input int n, input bit gap);
        int t;
        for (int i = first; i < first + n; i++) begin
            if (gap) begin rx_valid = 1'b0; @(negedge clk); end
            rx_data  = bq[i];
            rx_valid = 1'b1;
            t = 0;
            while (!rx_ready && t < 20) begin @(negedge clk); t++; end
            if (!rx_ready) begin
                checks++; errors++;
                $error("FAIL rx_ready_timeout: observed 0 expected 1");
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic start_boot();
        @(negedge clk);
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset values, then fetch path
        core_pc = 32'd4;
        for (int i = 0; i < 8; i++) poke(10'(i), 32'hA000_0000 | 32'(i));
        chk("rst_core_rst", core_rst, 0);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_done", boot_done, 0);
        chk("rst_err", boot_err, 0);
        chk("rst_busy", boot_busy, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t1_core_rst", core_rst, 1);
        chk("t1_instr_pc4", core_instr, 32'hA000_0001);
        core_pc = 32'hFFFF_F00C; #1;
        chk("t1_instr_wrap", core_instr, 32'hA000_0003);
        core_pc = 32'd7; #1;
        chk("t1_instr_lowbits", core_instr, 32'hA000_0001);
        core_pc = 32'd4;

        // 2: two-word load
        bq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        we0 = we_cnt; bad0 = rst_bad;
        start_boot();
        mon_rst = 1'b1;
        chk("t2_busy", boot_busy, 1);
        chk("t2_rx_ready", rx_ready, 1);
        chk("t2_core_rst", core_rst, 0);
        chk("t2_instr_zero", core_instr, 32'h0);
        stream(0, 12, 1'b0);
        chk("t2_we", mem_we, 1);
        chk("t2_addr", mem_addr, 1);
        chk("t2_wdata", mem_wdata, 32'h0020_0593);
        @(negedge clk);
        chk("t2_release_busy", boot_busy, 1);
        chk("t2_release_done", boot_done, 0);
        mon_rst = 1'b0;
        @(negedge clk);
        chk("t2_core_rst_up", core_rst, 1);
        chk("t2_done", boot_done, 1);
        chk("t2_idle_busy", boot_busy, 0);
        chk("t2_mem0", mem[0], 32'h0010_0513);
        chk("t2_mem1", mem[1], 32'h0020_0593);
        chk("t2_fetch", core_instr, 32'h0020_0593);
        chk("t2_we_cnt", 32'(we_cnt - we0), 2);
        chk("t2_rst_low", 32'(rst_bad - bad0), 0);

        // 3a: zero-length header
        bq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        we0 = we_cnt;
        start_boot();
        chk("t3a_done_clr", boot_done, 0);
        stream(0, 4, 1'b0);
        chk("t3a_err_state_rst", core_rst, 0);
        chk("t3a_err_state_busy", boot_busy, 0);
        chk("t3a_err_pending", boot_err, 0);
        @(negedge clk);
        chk("t3a_err", boot_err, 1);
        chk("t3a_core_rst", core_rst, 1);
        chk("t3a_rx_ready", rx_ready, 0);

        // 3b: N = 1025
        bq[0] = 8'h01; bq[1] = 8'h04;
        start_boot();
        chk("t3b_err_clr", boot_err, 0);
        stream(0, 4, 1'b0);
        @(negedge clk);
        chk("t3b_err", boot_err, 1);
        chk("t3b_core_rst", core_rst, 1);
        chk("t3_no_writes", 32'(we_cnt - we0), 0);
        chk("t3_mem0_kept", mem[0], 32'h0010_0513);

        // 3c: N = DEPTH is accepted, then aborted by reset
        bq[0] = 8'h00; bq[1] = 8'h04;
        start_boot();
        stream(0, 4, 1'b0);
        chk("t3c_busy", boot_busy, 1);
        chk("t3c_rx_ready", rx_ready, 1);
        chk("t3c_err", boot_err, 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t3c_core_rst", core_rst, 1);

        // 4: same load as 2 with rx_valid bubbles
        poke(10'd0, 32'h0); poke(10'd1, 32'h0);
        bq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        we0 = we_cnt;
        start_boot();
        stream(0, 12, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("t4_done", boot_done, 1);
        chk("t4_mem0", mem[0], 32'h0010_0513);
        chk("t4_mem1", mem[1], 32'h0020_0593);
        chk("t4_we_cnt", 32'(we_cnt - we0), 2);

        // 5: reset after header plus six data bytes
        poke(10'd0, 32'h0); poke(10'd1, 32'hDEAD_BEEF);
        we0 = we_cnt;
        start_boot();
        stream(0, 10, 1'b0);
        rst = 1'b0; #1;
        chk("t5_rx_ready", rx_ready, 0);
        chk("t5_core_rst", core_rst, 0);
        chk("t5_we", mem_we, 0);
        chk("t5_busy", boot_busy, 0);
        @(negedge clk);
        chk("t5_mem0", mem[0], 32'h0010_0513);
        chk("t5_mem1", mem[1], 32'hDEAD_BEEF);
        chk("t5_we_cnt", 32'(we_cnt - we0), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_core_rst_up", core_rst, 1);
        chk("t5_idle", boot_busy, 0);

        // 6: boot_req and fetches during a load are ignored
        bq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
        we0 = we_cnt;
        start_boot();
        stream(0, 6, 1'b0);
        boot_req = 1'b1;
        core_pc = 32'd0;   #1; chk("t6_instr_pc0", core_instr, 32'h0); chk("t6_addr_pc0", mem_addr, 0);
        @(negedge clk);
        core_pc = 32'd8;   #1; chk("t6_instr_pc8", core_instr, 32'h0); chk("t6_addr_pc8", mem_addr, 0);
        @(negedge clk);
        core_pc = 32'h100; #1; chk("t6_instr_pc100", core_instr, 32'h0);
        chk("t6_busy", boot_busy, 1);
        @(negedge clk);
        boot_req = 1'b0;
        core_pc = 32'd4;
        stream(6, 6, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t6_mem0", mem[0], 32'hDEAD_BEEF);
        chk("t6_mem1", mem[1], 32'h1234_5678);
        chk("t6_we_cnt", 32'(we_cnt - we0), 2);
        chk("t6_fetch", core_instr, 32'h1234_5678);
        @(negedge clk);
        chk("t6_no_restart_busy", boot_busy, 0);
        chk("t6_no_restart_ready", rx_ready, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
